// File: rtl/risc_pkg.sv
// Shared RV32I pipeline types: fetch FSM encoding and PC increment.
package risc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/fetch_redirect_ctrl_redirect_target.sv
// Redirect target for the EX-stage control-flow instruction plus misalignment flag.
module redirect_target
  import risc_pkg::*;
(
  input  logic        is_jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_imm,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] base;
  logic [31:0] sum;

  always_comb begin
    base = is_jalr ? ex_rs1 : ex_pc;
    sum  = base + ex_imm;
    // JALR drops bit 0 of the computed address; B/J targets are used as-is.
    target     = is_jalr ? {sum[31:1], 1'b0} : sum;
    misaligned = target[1];
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// PC owner for the IF stage: sequential fetch, EX-resolved redirects with flushes,
// stall/backpressure hold, and instruction-address-misaligned trap.
//
// state | meaning
// BOOT  | one idle cycle after reset, no fetch request
// RUN   | fetching; PC advances, holds, or is redirected
// TRAP  | misaligned target seen, PC parked at TRAP_VEC until exc_ack
module fetch_redirect_ctrl
  import risc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        branch_taken,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        exc_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        exc_valid,
  output logic [31:0] exc_tval,
  output logic [31:0] redirect_cnt
);

  fetch_state_e state_q, state_nxt;
  logic [31:0]  pc_q, pc_nxt;
  logic [31:0]  tval_q, tval_nxt;
  logic [31:0]  cnt_q, cnt_nxt;
  logic [31:0]  target;
  logic         misaligned;
  logic         redir;

  redirect_target u_redirect_target (
    .is_jalr    (is_jalr),
    .ex_pc      (ex_pc),
    .ex_rs1     (ex_rs1),
    .ex_imm     (ex_imm),
    .target     (target),
    .misaligned (misaligned)
  );

  assign redir = (state_q == RUN) & ex_valid & (branch_taken | is_jal | is_jalr);

  always_comb begin
    state_nxt   = state_q;
    pc_nxt      = pc_q;
    tval_nxt    = tval_q;
    cnt_nxt     = cnt_q;
    imem_req    = 1'b0;
    exc_valid   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    case (state_q)
      BOOT: state_nxt = RUN;
      RUN: begin
        imem_req    = 1'b1;
        flush_if_id = redir;
        flush_id_ex = redir;
        // A redirect replaces the PC even if the pending request was never accepted.
        if (redir) begin
          if (misaligned) begin
            pc_nxt    = TRAP_VEC;
            tval_nxt  = target;
            state_nxt = TRAP;
          end else begin
            pc_nxt = target;
            if (cnt_q != 32'hFFFF_FFFF) cnt_nxt = cnt_q + 32'd1;
          end
        end else if (!(stall || !imem_ready)) begin
          pc_nxt = pc_q + PC_INCR;
        end
      end
      TRAP: begin
        exc_valid = 1'b1;
        if (exc_ack) state_nxt = RUN;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      tval_q  <= 32'h0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      tval_q  <= tval_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign imem_addr    = pc_q;
  assign exc_tval     = tval_q;
  assign redirect_cnt = cnt_q;

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Program-counter owner and control-flow redirect controller for the RV32I 5-stage pipeline. Consumes `branch_taken` from `branch_control` plus EX-stage JAL/JALR qualifiers, computes the redirect target, and drives the IF-stage PC and instruction-memory request. It also issues the IF/ID and ID/EX flushes for a resolved redirect, holds the PC on stall or memory backpressure, and traps on a misaligned target.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `TRAP_VEC`, 32'h0000_0100, PC loaded on misaligned-target trap.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `ex_valid` in 1: EX stage holds a real instruction; unqualified EX inputs are ignored.
- `branch_taken` in 1: from `branch_control`, already ANDed with is_b_type.
- `is_jal` in 1: EX instruction is JAL.
- `is_jalr` in 1: EX instruction is JALR.
- `ex_pc` in 32: PC of the EX instruction.
- `ex_imm` in 32: sign-extended B/J/I immediate.
- `ex_rs1` in 32: forwarded rs1 value, used by JALR.
- `stall` in 1: load-use stall from the hazard unit.
- `imem_ready` in 1: instruction memory accepts the request this cycle.
- `exc_ack` in 1: trap handler acknowledge.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address, equal to the PC register.
- `flush_if_id` out 1: squash the IF/ID register.
- `flush_id_ex` out 1: squash the ID/EX register.
- `exc_valid` out 1: instruction-address-misaligned trap pending.
- `exc_tval` out 32: the faulting target.
- `redirect_cnt` out 32: saturating count of taken redirects.

## Operation
- **Redirect condition:** `redir = ex_valid & (branch_taken | is_jal | is_jalr)`.
- **Target:**
  - JALR: `(ex_rs1 + ex_imm) & ~32'h1`.
  - Otherwise: `ex_pc + ex_imm`.
  - Arithmetic is 32-bit modulo 2^32, and carry is discarded, so 32'hFFFF_FFFC + 8 yields 32'h0000_0004.
- **Misaligned target:** if `target[1] = 1`, no redirect to the target occurs.
  - PC is loaded with `TRAP_VEC`.
  - `exc_tval` captures the target.
  - The FSM enters TRAP.
- **FSM states:**
  - BOOT: one cycle after reset release. `imem_req = 0`. Goes to RUN unconditionally.
  - RUN: normal fetch, `imem_req = 1`.
  - TRAP: `imem_req = 0`, `exc_valid = 1`. Goes to RUN on `exc_ack`; the PC is already `TRAP_VEC`.
- **PC update in RUN, by priority:**
  1. `redir` with aligned target: PC ← target.
  2. `redir` with misaligned target: PC ← `TRAP_VEC`, go to TRAP.
  3. `stall`, or `imem_req & !imem_ready`: PC holds.
  4. Otherwise: PC ← PC + 4.
- **Redirect vs stall:** a redirect overrides both `stall` and backpressure. The PC is replaced even if the old request was never accepted.
- **Flushes:** `flush_if_id = flush_id_ex = redir` (RUN only). They are combinational, in the same cycle as the redirect, and asserted for both aligned and misaligned targets.
- **Redirects outside RUN:** ignored in BOOT and TRAP; no flush, no count.
- **`redirect_cnt`:**
  - Increments on each accepted aligned redirect in RUN.
  - Saturates at 32'hFFFF_FFFF.
  - Misaligned traps are not counted.
- **Reset values:**
  - PC = `RESET_PC`, state = BOOT.
  - `imem_req = 0`, `exc_valid = 0`, `exc_tval = 0`, `redirect_cnt = 0`.
  - Flushes = 0.
- **Reset mid-operation:** synchronous reset wins over every other input in the same cycle, including TRAP and a pending redirect.

## Timing
- **Redirect latency:** redirect resolved in EX in cycle N → `imem_addr = target` in N+1. This is a two-instruction penalty, both killed by the cycle-N flushes.
- **First fetch:** reset deasserted at edge E → BOOT in the cycle after E → first `imem_req` with `RESET_PC` one cycle later.
- **Handshake:** a request transfers when `imem_req & imem_ready`. `imem_addr` is stable while `imem_req & !imem_ready`, except on `redir`.
- **Trap timing:**
  - `exc_valid` rises the cycle after the misaligned redirect and holds until `exc_ack` is sampled high.
  - Fetch resumes at `TRAP_VEC` one cycle after that.
  - `exc_ack` with `exc_valid = 0` has no effect.

## Structure
- **Add to `risc_pkg`:**
  - `fetch_state_e` enum: BOOT, RUN, TRAP.
  - `PC_INCR = 32'd4` constant.
- **Sub-module `redirect_target`:** combinational, computes the target plus the misaligned flag from `is_jalr`, `ex_pc`, `ex_rs1`, and `ex_imm`.
- **Top level:** holds the FSM, PC register, `exc_tval` and counter.

## Test plan
- **Reset and sequential fetch:** reset, then `imem_ready = 1` for 4 cycles → BOOT with `imem_req = 0`, then addresses 0x0, 0x4, 0x8, 0xC.
- **Taken branch:** branch taken at `ex_pc = 0x40`, `ex_imm = 0x20` → both flushes high the same cycle, next `imem_addr = 0x60`, `redirect_cnt = 1`.
- **JALR with bit-0 clear:** JALR with `ex_rs1 = 0x1001`, `ex_imm = 0x4` → target 0x1004 (bit0 cleared), no trap.
- **Backpressure, stall, and override:**
  - `imem_ready = 0` for 3 cycles at 0x8 → address held at 0x8.
  - `stall` at 0xC → held.
  - A redirect to 0x80 during `stall` → next address 0x80.
- **Misaligned target:** JAL with `ex_pc = 0x10`, `ex_imm = 0x6` → flushes high, `exc_valid = 1`, `exc_tval = 0x16`, `imem_req = 0` until `exc_ack`, then fetch at 0x100.
- **Reset and wrap-around:**
  - `rst_n` low while in TRAP → BOOT, `exc_valid = 0`, `redirect_cnt = 0`.
  - Branch from `ex_pc = 0xFFFF_FFF0` with `ex_imm = 0x14` → target 0x4.
